joy_serializer: RTL

JOY_SERIALIZER -- requirements
Module: joy_serializer

---
 rtl/joy_ser_pkg.sv | 8 +
 rtl/joy_ser_sync_filter.sv | 38 +++
 rtl/joy_serializer.sv | 57 +++++
 3 files changed

// File: rtl/joy_ser_pkg.sv
// joy_ser_pkg: shared defaults, idle level and synchronizer reset values for joy_serializer
package joy_ser_pkg;
  localparam int DEF_CHAIN_LEN = 16;
  localparam int DEF_FILTER_CYCLES = 4;
  localparam logic IDLE_LVL = 1'b1;
  localparam logic SYNC_RST_CLK = 1'b0;
  localparam logic SYNC_RST_LOAD = 1'b1;
endpackage

// File: rtl/joy_ser_sync_filter.sv
// joy_ser_sync_filter: 2-flop synchronizer with an optional glitch filter (JOY_SER_FILTER_EN)
module joy_ser_sync_filter
  import joy_ser_pkg::*;
#(
  parameter logic RST_VAL = SYNC_RST_CLK,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= {2{RST_VAL}};
    else sync <= {sync[0], din};
`ifdef JOY_SER_FILTER_EN
  localparam int RW = $clog2(FILTER_CYCLES + 1);
  logic [RW-1:0] run;
  logic lvl;
  // run counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run <= '0;
      lvl <= RST_VAL;
    end else if (sync[1] == lvl) run <= '0;
    else if (run == RW'(FILTER_CYCLES - 1)) begin
      run <= '0;
      lvl <= sync[1];
    end else run <= run + 1'b1;
  assign dout = lvl;
`else
  // FILTER_CYCLES is kept so both builds share one parameter list
  if (FILTER_CYCLES < 1) begin : g_no_filter
  end
  assign dout = sync[1];
`endif
endmodule

// File: rtl/joy_serializer.sv
// joy_serializer: 74HC165-chain emulator driven by external shift/load strobes
// optional input glitch filter enabled by defining JOY_SER_FILTER_EN
module joy_serializer
  import joy_ser_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           joy_clk_in,
  input  logic                           joy_load_n_in,
  input  logic [CHAIN_LEN-1:0]           par_in,
  output logic                           joy_data,
  output logic                           frame_done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  logic jc, ld, jc_q, rise, done_nxt;
  logic [CHAIN_LEN-1:0] shreg, shreg_nxt;
  logic [CW-1:0] cnt_nxt;
  joy_ser_sync_filter #(.RST_VAL(SYNC_RST_CLK), .FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
    .clk(clk), .reset_n(reset_n), .din(joy_clk_in), .dout(jc)
  );
  joy_ser_sync_filter #(.RST_VAL(SYNC_RST_LOAD), .FILTER_CYCLES(FILTER_CYCLES)) u_load_sync (
    .clk(clk), .reset_n(reset_n), .din(joy_load_n_in), .dout(ld)
  );
  // jc_q follows jc even during load, so an edge seen under load is consumed there
  assign rise = jc & ~jc_q;
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt = bit_cnt;
    done_nxt = 1'b0;
    if (!ld) begin
      shreg_nxt = par_in;
      cnt_nxt = '0;
    end else if (rise) begin
      shreg_nxt = {shreg[CHAIN_LEN-2:0], IDLE_LVL};
      cnt_nxt = (bit_cnt == CW'(CHAIN_LEN)) ? bit_cnt : bit_cnt + 1'b1;
      done_nxt = bit_cnt == CW'(CHAIN_LEN - 1);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      jc_q <= SYNC_RST_CLK;
      shreg <= {CHAIN_LEN{IDLE_LVL}};
      bit_cnt <= '0;
      frame_done <= 1'b0;
      joy_data <= IDLE_LVL;
    end else begin
      jc_q <= jc;
      shreg <= shreg_nxt;
      bit_cnt <= cnt_nxt;
      frame_done <= done_nxt;
      joy_data <= shreg_nxt[CHAIN_LEN-1];
    end
endmodule
